// File: rtl/scroll_sequencer.sv
// rtl/scroll_sequencer.sv - step-rate divider, index, message, direction and pause control for the HEX5..HEX0 scroller
module scroll_sequencer #(
  parameter  int CLK_HZ  = 50_000_000,
  parameter  int STEP_HZ = 2,
  parameter  int NUM_MSG = 4,
  parameter  int MAX_LEN = 32,
  localparam int IDX_W   = $clog2(MAX_LEN),
  localparam int SEL_W   = $clog2(NUM_MSG)
) (
  input  logic             MAX10_CLK1_50,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             dir,
  input  logic             oneshot,
  input  logic [SEL_W-1:0] msg_sel,
  input  logic [IDX_W:0]   msg_len,
  output logic [SEL_W-1:0] msg_id,
  output logic [IDX_W-1:0] index,
  output logic             step,
  output logic             wrap,
  output logic             done,
  output logic             busy
);

  localparam int DIV   = CLK_HZ / STEP_HZ;
  localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [IDX_W:0]   MAX_L    = (IDX_W + 1)'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSED,
    S_SWITCH
  } state_t;

  state_t           state, state_nx;
  logic [DIV_W-1:0] divcnt, divcnt_nx;
  logic [IDX_W-1:0] index_nx;
  logic [SEL_W-1:0] msg_id_nx;
  logic             step_nx, wrap_nx, done_nx;

  logic [IDX_W:0]   eff_len;
  logic [IDX_W-1:0] last_idx;
  logic             at_div_last;
  logic             overrun;
  logic             move;
  logic             wrap_evt;
  logic [IDX_W-1:0] idx_new;

  // A zero-length message still occupies one position; oversize lengths clamp to the buffer.
  always_comb begin
    eff_len = msg_len;
    if (msg_len == '0) begin
      eff_len = (IDX_W + 1)'(1);
    end else if (msg_len > MAX_L) begin
      eff_len = MAX_L;
    end
  end

  assign last_idx    = IDX_W'(eff_len - 1'b1);
  assign at_div_last = (divcnt == DIV_LAST);
  assign overrun     = (index > last_idx);

  // Index movement for a RUN cycle: a shrunk message realigns immediately, otherwise the divider decides.
  always_comb begin
    move     = 1'b0;
    wrap_evt = 1'b0;
    idx_new  = index;
    if (overrun) begin
      move     = 1'b1;
      wrap_evt = 1'b1;
      idx_new  = dir ? last_idx : '0;
    end else if (at_div_last) begin
      move = 1'b1;
      if (!dir) begin
        if (index == last_idx) begin
          wrap_evt = 1'b1;
          idx_new  = '0;
        end else begin
          idx_new = index + 1'b1;
        end
      end else begin
        if (index == '0) begin
          wrap_evt = 1'b1;
          idx_new  = last_idx;
        end else begin
          idx_new = index - 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nx  = state;
    divcnt_nx = divcnt;
    index_nx  = index;
    msg_id_nx = msg_id;
    step_nx   = 1'b0;
    wrap_nx   = 1'b0;
    done_nx   = 1'b0;

    if (stop) begin
      state_nx  = S_IDLE;
      index_nx  = '0;
      divcnt_nx = '0;
    end else begin
      case (state)
        S_IDLE: begin
          index_nx  = '0;
          divcnt_nx = '0;
          if (start) begin
            state_nx  = S_SWITCH;
            msg_id_nx = msg_sel;
          end
        end

        // msg_id changed on entry, so msg_len already describes the new message here.
        S_SWITCH: begin
          divcnt_nx = '0;
          index_nx  = dir ? last_idx : '0;
          state_nx  = S_RUN;
        end

        // A PAUSED cycle with pause released behaves as a RUN cycle so the held count resumes at once.
        S_RUN, S_PAUSED: begin
          if (pause) begin
            state_nx = S_PAUSED;
          end else if (msg_sel != msg_id) begin
            state_nx  = S_SWITCH;
            msg_id_nx = msg_sel;
            divcnt_nx = '0;
          end else begin
            state_nx  = S_RUN;
            divcnt_nx = at_div_last ? '0 : divcnt + 1'b1;
            if (move) begin
              if (wrap_evt && oneshot) begin
                state_nx = S_IDLE;
                index_nx = '0;
                done_nx  = 1'b1;
              end else begin
                index_nx = idx_new;
                step_nx  = 1'b1;
                wrap_nx  = wrap_evt;
              end
            end
          end
        end

        default: begin
          state_nx = S_IDLE;
          index_nx = '0;
        end
      endcase
    end
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (rst) begin
      state  <= S_IDLE;
      divcnt <= '0;
      index  <= '0;
      msg_id <= '0;
      step   <= 1'b0;
      wrap   <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nx;
      divcnt <= divcnt_nx;
      index  <= index_nx;
      msg_id <= msg_id_nx;
      step   <= step_nx;
      wrap   <= wrap_nx;
      done   <= done_nx;
      busy   <= (state_nx != S_IDLE);
    end
  end

endmodule

// File: tb/tb_scroll_sequencer.sv
// tb/tb_scroll_sequencer.sv - directed and randomized bench for scroll_sequencer against a behavioural model
`timescale 1ns/1ps
module tb_scroll_sequencer;

  localparam int DIV     = 4;
  localparam int NUM_MSG = 4;
  localparam int MAX_LEN = 32;
  localparam int IDX_W   = 5;
  localparam int SEL_W   = 2;

  localparam int M_OFF  = 0;
  localparam int M_LOAD = 1;
  localparam int M_GO   = 2;
  localparam int M_HOLD = 3;

  logic             clk = 1'b0;
  logic             rst, start, stop, pause, dir, oneshot;
  logic [SEL_W-1:0] msg_sel;
  logic [SEL_W-1:0] msg_id;
  logic [IDX_W:0]   msg_len;
  logic [IDX_W-1:0] index;
  logic             step, wrap, done, busy;
  logic [IDX_W:0]   len_tab [NUM_MSG];

  assign msg_len = len_tab[msg_id];

  scroll_sequencer #(
    .CLK_HZ (8),
    .STEP_HZ(2),
    .NUM_MSG(NUM_MSG),
    .MAX_LEN(MAX_LEN)
  ) dut (
    .MAX10_CLK1_50(clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .pause        (pause),
    .dir          (dir),
    .oneshot      (oneshot),
    .msg_sel      (msg_sel),
    .msg_len      (msg_len),
    .msg_id       (msg_id),
    .index        (index),
    .step         (step),
    .wrap         (wrap),
    .done         (done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model: mode, cycles remaining until the next step, position, message
  int m_mode = M_OFF;
  int m_left = DIV;
  int m_idx  = 0;
  int m_id   = 0;
  bit e_step = 1'b0;
  bit e_wrap = 1'b0;
  bit e_done = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int  len;
    int  nxt;
    bit  moved;
    bit  wr;
    len    = (len_tab[m_id] == 0) ? 1 : int'(len_tab[m_id]);
    nxt    = m_idx;
    moved  = 1'b0;
    wr     = 1'b0;
    e_step = 1'b0;
    e_wrap = 1'b0;
    e_done = 1'b0;
    if (rst) begin
      m_mode = M_OFF;
      m_idx  = 0;
      m_id   = 0;
      m_left = DIV;
    end else if (stop) begin
      m_mode = M_OFF;
      m_idx  = 0;
    end else begin
      case (m_mode)
        M_OFF: begin
          m_idx = 0;
          if (start) begin
            m_mode = M_LOAD;
            m_id   = int'(msg_sel);
          end
        end
        M_LOAD: begin
          m_left = DIV;
          m_idx  = dir ? len - 1 : 0;
          m_mode = M_GO;
        end
        default: begin
          if (pause) begin
            m_mode = M_HOLD;
          end else if (int'(msg_sel) != m_id) begin
            m_mode = M_LOAD;
            m_id   = int'(msg_sel);
            m_left = DIV;
          end else begin
            m_mode = M_GO;
            if (m_idx >= len) begin
              nxt   = dir ? len - 1 : 0;
              wr    = 1'b1;
              moved = 1'b1;
            end
            if (m_left == 1) begin
              m_left = DIV;
              if (!moved) begin
                moved = 1'b1;
                if (!dir) begin
                  nxt = (m_idx + 1) % len;
                  wr  = (nxt == 0);
                end else begin
                  nxt = (m_idx + len - 1) % len;
                  wr  = (nxt == len - 1);
                end
              end
            end else begin
              m_left = m_left - 1;
            end
            if (moved) begin
              if (wr && oneshot) begin
                m_mode = M_OFF;
                m_idx  = 0;
                e_done = 1'b1;
              end else begin
                m_idx  = nxt;
                e_step = 1'b1;
                e_wrap = wr;
              end
            end
          end
        end
      endcase
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("index", int'(index), m_idx);
    check("msg_id", int'(msg_id), m_id);
    check("step", int'(step), int'(e_step));
    check("wrap", int'(wrap), int'(e_wrap));
    check("done", int'(done), int'(e_done));
    check("busy", int'(busy), (m_mode != M_OFF) ? 1 : 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic halt();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    dir = 1'b0; oneshot = 1'b0; msg_sel = '0;
    len_tab[0] = 6'd5; len_tab[1] = 6'd4; len_tab[2] = 6'd3; len_tab[3] = 6'd0;
    @(negedge clk);
    tick();
    tick();
    check("rst_index", int'(index), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_msg_id", int'(msg_id), 0);
    rst = 1'b0;

    // left scroll over a 4-character message
    msg_sel = 2'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("sw_msg_id", int'(msg_id), 1);
    check("sw_busy", int'(busy), 1);
    tick();
    check("left_first", int'(index), 0);
    ticks(3);
    check("left_nostep", int'(step), 0);
    tick();
    check("left_step", int'(step), 1);
    check("left_idx1", int'(index), 1);
    ticks(8);
    check("left_idx3", int'(index), 3);
    ticks(4);
    check("left_wrap_idx", int'(index), 0);
    check("left_wrap", int'(wrap), 1);
    halt();

    // right scroll
    dir = 1'b1;
    go();
    check("right_first", int'(index), 3);
    ticks(4);
    check("right_idx2", int'(index), 2);
    ticks(8);
    check("right_idx0", int'(index), 0);
    check("right_nowrap", int'(wrap), 0);
    ticks(4);
    check("right_wrap_idx", int'(index), 3);
    check("right_wrap", int'(wrap), 1);
    halt();

    // one pass over a 3-character message
    dir = 1'b0; oneshot = 1'b1; msg_sel = 2'd2;
    go();
    ticks(8);
    check("os_idx2", int'(index), 2);
    ticks(4);
    check("os_done", int'(done), 1);
    check("os_step", int'(step), 0);
    check("os_busy", int'(busy), 0);
    check("os_idx", int'(index), 0);
    oneshot = 1'b0;

    // pause while the divider sits on its last count
    msg_sel = 2'd1;
    go();
    ticks(3);
    pause = 1'b1;
    ticks(10);
    check("pause_idx", int'(index), 0);
    check("pause_busy", int'(busy), 1);
    pause = 1'b0;
    tick();
    check("resume_step", int'(step), 1);
    check("resume_idx", int'(index), 1);

    // message change mid-scroll restarts the pass
    ticks(4);
    check("pre_sw_idx", int'(index), 2);
    msg_sel = 2'd2;
    tick();
    check("chg_msg_id", int'(msg_id), 2);
    tick();
    check("chg_idx", int'(index), 0);
    ticks(3);
    check("chg_nostep", int'(step), 0);
    tick();
    check("chg_step", int'(step), 1);
    halt();
    check("stop_busy", int'(busy), 0);
    check("stop_done", int'(done), 0);

    // zero-length message behaves as length one
    msg_sel = 2'd3;
    go();
    ticks(4);
    check("len0_step", int'(step), 1);
    check("len0_wrap", int'(wrap), 1);
    check("len0_idx", int'(index), 0);
    halt();

    // message shrinks under the current index
    len_tab[1] = 6'd8; msg_sel = 2'd1;
    go();
    ticks(20);
    check("shr_pre", int'(index), 5);
    len_tab[1] = 6'd3;
    tick();
    check("shr_idx", int'(index), 0);
    check("shr_wrap", int'(wrap), 1);

    // reset mid-scroll
    ticks(5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_msg_id", int'(msg_id), 0);

    for (int c = 0; c < 4000; c++) begin
      rst   = ($urandom_range(0, 999) == 0);
      start = ($urandom_range(0, 19) == 0);
      stop  = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 29) == 0) pause = ~pause;
      if ($urandom_range(0, 39) == 0) dir = ~dir;
      if ($urandom_range(0, 49) == 0) oneshot = ~oneshot;
      if ($urandom_range(0, 59) == 0) msg_sel = SEL_W'($urandom_range(0, NUM_MSG - 1));
      if ($urandom_range(0, 69) == 0) begin
        if ($urandom_range(0, 9) == 0) len_tab[$urandom_range(0, NUM_MSG - 1)] = 6'(MAX_LEN);
        else len_tab[$urandom_range(0, NUM_MSG - 1)] = 6'($urandom_range(0, 12));
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
